mac_accum_drain: RTL and testbench

- Downstream consumer of the four mac_block_N product outputs.
- Combines the four per-block C words into lanes according to the MAC width mode.
- Accumulates a burst of input beats, then serializes the lane results out over a valid/ready stream.
- Sits between the mac_block array and the result writeback path.

---
 rtl/mac_accum_drain.sv | 163 ++++++++++++++++
 tb/tb_mac_accum_drain.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_drain.sv
// mac_accum_drain: folds the four mac_block C words into 1, 2 or 4 lanes,
// accumulates a burst of beats per lane, then streams the lane totals out.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. valid, once raised, is held with its data/lane/last stable
// until the transfer completes; ready may change freely.
`timescale 1ns/1ps

module mac_accum_drain #(
   parameter int MIN_W = 8,
   parameter int INT_W = 40,
   parameter int ACC_W = 48,
   parameter int LEN_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       cfg_mode,
   input  logic [LEN_W-1:0] cfg_len,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [INT_W-1:0] c0,
   input  logic [INT_W-1:0] c1,
   input  logic [INT_W-1:0] c2,
   input  logic [INT_W-1:0] c3,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_data,
   output logic [1:0]       out_lane,
   output logic             out_last,
   output logic             busy,
   output logic             cfg_err,
   output logic [1:0]       dbg_state
);

   localparam logic [1:0] MODE_SINGLE = 2'd0;
   localparam logic [1:0] MODE_DUAL   = 2'd1;
   localparam logic [1:0] MODE_QUAD   = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ACCUM = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t           state;
   logic [1:0]       mode_r;
   logic [LEN_W-1:0] len_r;
   logic [LEN_W-1:0] cnt;
   logic [ACC_W-1:0] acc  [4];
   logic [ACC_W-1:0] lane [4];
   logic [1:0]       last_idx;
   logic [1:0]       idx_nx;

   // The low ACC_W bits of a sum depend only on the low ACC_W bits of its
   // terms, so forming lanes directly at ACC_W equals forming them at
   // INT_W+3*MIN_W and truncating afterwards.
   logic [ACC_W-1:0] x0, x1, x2, x3;
   assign x0 = ACC_W'(c0);
   assign x1 = ACC_W'(c1);
   assign x2 = ACC_W'(c2);
   assign x3 = ACC_W'(c3);

   // Lane formation from the latched mode; lanes a mode does not use stay 0
   always_comb begin
      for (int k = 0; k < 4; k++) lane[k] = '0;
      case (mode_r)
         MODE_SINGLE: begin
            lane[0] = x0;
            lane[1] = x1;
            lane[2] = x2;
            lane[3] = x3;
         end
         MODE_DUAL: begin
            lane[0] = x0 + (x1 << MIN_W);
            lane[1] = x2 + (x3 << MIN_W);
         end
         MODE_QUAD: begin
            lane[0] = x0 + (x1 << MIN_W) + (x2 << (2 * MIN_W)) + (x3 << (3 * MIN_W));
         end
         default: ;
      endcase
   end

   // Index of the final lane emitted in the latched mode
   always_comb begin
      case (mode_r)
         MODE_SINGLE: last_idx = 2'd3;
         MODE_DUAL:   last_idx = 2'd1;
         default:     last_idx = 2'd0;
      endcase
   end

   assign idx_nx    = out_lane + 2'd1;
   assign out_data  = acc[out_lane];
   assign dbg_state = state;

   // Control FSM with registered handshake/status outputs and accumulators
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= S_IDLE;
         mode_r    <= MODE_SINGLE;
         len_r     <= '0;
         cnt       <= '0;
         for (int k = 0; k < 4; k++) acc[k] <= '0;
         out_lane  <= 2'd0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         busy      <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         cfg_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  if (cfg_mode == MODE_SINGLE || cfg_mode == MODE_DUAL || cfg_mode == MODE_QUAD) begin
                     mode_r   <= cfg_mode;
                     len_r    <= cfg_len;
                     cnt      <= '0;
                     for (int k = 0; k < 4; k++) acc[k] <= '0;
                     out_lane <= 2'd0;
                     in_ready <= 1'b1;
                     busy     <= 1'b1;
                     state    <= S_ACCUM;
                  end else begin
                     cfg_err <= 1'b1;
                  end
               end
            end
            S_ACCUM: begin
               if (in_valid) begin
                  for (int k = 0; k < 4; k++) acc[k] <= acc[k] + lane[k];
                  cnt <= cnt + LEN_W'(1);
                  if (cnt == len_r) begin
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_lane  <= 2'd0;
                     out_last  <= (last_idx == 2'd0);
                     state     <= S_DRAIN;
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  if (out_last) begin
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     out_lane  <= 2'd0;
                     busy      <= 1'b0;
                     state     <= S_IDLE;
                  end else begin
                     out_lane <= idx_nx;
                     out_last <= (idx_nx == last_idx);
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accum_drain.sv
// Bench for mac_accum_drain: directed and random bursts, a lane-sum model
// feeding an expected queue, and a negedge monitor that checks every
// presented output word against the queue head.
`timescale 1ns/1ps

module tb_mac_accum_drain;

   localparam int MIN_W = 8;
   localparam int INT_W = 40;
   localparam int ACC_W = 48;
   localparam int LEN_W = 8;
   localparam int W     = ACC_W + 3;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [1:0]       cfg_mode = 2'd0;
   logic [LEN_W-1:0] cfg_len = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [INT_W-1:0] c0 = '0, c1 = '0, c2 = '0, c3 = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [ACC_W-1:0] out_data;
   logic [1:0]       out_lane;
   logic             out_last;
   logic             busy;
   logic             cfg_err;
   logic [1:0]       dbg_state;

   mac_accum_drain #(.MIN_W(MIN_W), .INT_W(INT_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
      .in_valid(in_valid), .in_ready(in_ready),
      .c0(c0), .c1(c1), .c2(c2), .c3(c3),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_lane(out_lane), .out_last(out_last), .busy(busy), .cfg_err(cfg_err),
      .dbg_state(dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int tests = 0;
   int fails = 0;
   logic [W-1:0]     exp_q[$];
   logic [INT_W-1:0] bc [256][4];
   int first_acc_edge = -1;
   int last_hs_edge   = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: each lane is the plain integer weighted sum of the C words,
   // totalled over the burst and reduced modulo 2^ACC_W.
   function automatic void push_expected(input logic [1:0] mode, input int len);
      logic [63:0] sum [4];
      logic [63:0] mask;
      int nl;
      mask = (64'd1 << ACC_W) - 64'd1;
      for (int k = 0; k < 4; k++) sum[k] = 64'd0;
      for (int b = 0; b <= len; b++) begin
         case (mode)
            2'd0: for (int k = 0; k < 4; k++) sum[k] = (sum[k] + 64'(bc[b][k])) & mask;
            2'd1: begin
               sum[0] = (sum[0] + 64'(bc[b][0]) + 64'(bc[b][1]) * 64'd256) & mask;
               sum[1] = (sum[1] + 64'(bc[b][2]) + 64'(bc[b][3]) * 64'd256) & mask;
            end
            default: sum[0] = (sum[0] + 64'(bc[b][0]) + 64'(bc[b][1]) * 64'd256
                               + 64'(bc[b][2]) * 64'd65536 + 64'(bc[b][3]) * 64'd16777216) & mask;
         endcase
      end
      nl = (mode == 2'd0) ? 4 : ((mode == 2'd1) ? 2 : 1);
      for (int k = 0; k < nl; k++)
         exp_q.push_back({(k == nl - 1) ? 1'b1 : 1'b0, 2'(k), sum[k][ACC_W-1:0]});
   endfunction

   function automatic logic [INT_W-1:0] rnd_c();
      return INT_W'({$urandom(), $urandom()});
   endfunction

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (rst && out_valid) begin
         check("in_ready_during_drain", 64'(in_ready), 64'd0);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_output: got lane %0d data 0x%0h, none expected", out_lane, out_data);
         end else begin
            check($sformatf("out_word_lane%0d", exp_q[0][ACC_W+1:ACC_W]),
                  64'({out_last, out_lane, out_data}), 64'(exp_q[0]));
            if (out_ready) begin
               if (out_last) last_hs_edge = cyc + 1;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // ---------------- driver ----------------
   task automatic run_burst(input logic [1:0] mode, input int len, input bit bubbles,
                            input bit rnd_ready, input bit bp);
      int  guard;
      int  hold;
      bit  done;
      push_expected(mode, len);
      out_ready = !rnd_ready;
      start     = 1'b1;
      cfg_mode  = mode;
      cfg_len   = LEN_W'(len);
      tick();
      start = 1'b0;
      first_acc_edge = -1;
      for (int b = 0; b <= len; b++) begin
         guard = 0;
         done  = 1'b0;
         while (!done && guard < 50) begin
            if (bubbles && $urandom_range(0, 3) == 0) begin
               in_valid = 1'b0;
            end else begin
               in_valid = 1'b1;
               c0 = bc[b][0]; c1 = bc[b][1]; c2 = bc[b][2]; c3 = bc[b][3];
            end
            done = in_valid && in_ready;
            if (done && first_acc_edge < 0) first_acc_edge = cyc + 1;
            tick();
            guard++;
         end
         if (!done) check("beat_accept_timeout", 64'd0, 64'd1);
      end
      in_valid = 1'b0;
      guard = 0;
      hold  = 0;
      while (busy && guard < 300) begin
         if (bp && out_valid && out_lane == 2'd1 && hold < 5) begin
            out_ready = 1'b0;
            hold++;
         end else if (rnd_ready) begin
            out_ready = 1'($urandom_range(0, 1));
         end else begin
            out_ready = 1'b1;
         end
         in_valid = 1'($urandom_range(0, 1));
         c0 = rnd_c(); c1 = rnd_c(); c2 = rnd_c(); c3 = rnd_c();
         tick();
         guard++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("busy_low_after_burst", 64'(busy), 64'd0);
      if (bp) check("backpressure_hold_cycles", 64'(hold), 64'd5);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      #1 rst = 1'b0;
      #1;
      check("reset_out_valid", 64'(out_valid), 64'd0);
      check("reset_in_ready",  64'(in_ready),  64'd0);
      check("reset_busy",      64'(busy),      64'd0);
      check("reset_out_data",  64'(out_data),  64'd0);
      check("reset_out_lane",  64'(out_lane),  64'd0);
      check("reset_out_last",  64'(out_last),  64'd0);
      check("reset_cfg_err",   64'(cfg_err),   64'd0);
      check("reset_state",     64'(dbg_state), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      tick();

      // SINGLE, two beats; also the N+4 latency with out_ready high
      bc[0] = '{40'd1, 40'd2, 40'd3, 40'd4};
      bc[1] = '{40'd10, 40'd20, 40'd30, 40'd40};
      run_burst(2'd0, 1, 1'b0, 1'b0, 1'b0);
      check("single_latency_edges", 64'(last_hs_edge - first_acc_edge + 1), 64'd6);

      // DUAL, single beat
      bc[0] = '{40'h05, 40'h02, 40'h01, 40'h01};
      run_burst(2'd1, 0, 1'b0, 1'b0, 1'b0);

      // QUAD, three beats of ones
      for (int b = 0; b < 3; b++) bc[b] = '{40'd1, 40'd1, 40'd1, 40'd1};
      run_burst(2'd2, 2, 1'b0, 1'b0, 1'b0);

      // Backpressure held on lane 1
      for (int b = 0; b < 4; b++) bc[b] = '{rnd_c(), rnd_c(), rnd_c(), rnd_c()};
      run_burst(2'd0, 3, 1'b0, 1'b0, 1'b1);

      // Wrap: max c0 twice, then a QUAD sum that overflows 48 bits
      for (int b = 0; b < 2; b++) bc[b] = '{{INT_W{1'b1}}, 40'd0, 40'd0, 40'd0};
      run_burst(2'd0, 1, 1'b0, 1'b0, 1'b0);
      for (int b = 0; b < 2; b++) bc[b] = '{{INT_W{1'b1}}, {INT_W{1'b1}}, {INT_W{1'b1}}, {INT_W{1'b1}}};
      run_burst(2'd2, 1, 1'b0, 1'b0, 1'b0);

      // Illegal mode
      start = 1'b1;
      cfg_mode = 2'd3;
      cfg_len = 8'd2;
      tick();
      start = 1'b0;
      check("illegal_cfg_err_pulse", 64'(cfg_err), 64'd1);
      check("illegal_busy", 64'(busy), 64'd0);
      check("illegal_state", 64'(dbg_state), 64'd0);
      tick();
      check("illegal_cfg_err_clears", 64'(cfg_err), 64'd0);

      // Random bursts
      for (int t = 0; t < 25; t++) begin
         int len;
         logic [1:0] mode;
         mode = 2'($urandom_range(0, 2));
         len  = $urandom_range(0, 9);
         for (int b = 0; b <= len; b++) bc[b] = '{rnd_c(), rnd_c(), rnd_c(), rnd_c()};
         run_burst(mode, len, 1'b1, 1'b1, 1'b0);
      end

      // Reset in the middle of an accumulate phase
      start = 1'b1;
      cfg_mode = 2'd2;
      cfg_len = 8'd20;
      tick();
      start = 1'b0;
      in_valid = 1'b1;
      c0 = rnd_c(); c1 = rnd_c(); c2 = rnd_c(); c3 = rnd_c();
      repeat (3) tick();
      #2 rst = 1'b0;
      #1;
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready",  64'(in_ready),  64'd0);
      check("abort_busy",      64'(busy),      64'd0);
      check("abort_out_data",  64'(out_data),  64'd0);
      check("abort_out_last",  64'(out_last),  64'd0);
      check("abort_state",     64'(dbg_state), 64'd0);
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();

      // Recovery after abort
      bc[0] = '{40'd7, 40'd8, 40'd9, 40'd10};
      run_burst(2'd0, 0, 1'b0, 1'b0, 1'b0);

      repeat (3) tick();
      check("expected_queue_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
